// File: rtl/mux4_arb_pkg.sv
// mux4_arb_pkg: shared constants, FSM states and pointer helper for the 4-way round-robin arbiter
package mux4_arb_pkg;
   localparam int NUM_REQ = 4;
   localparam int SEL_W = 2;
   typedef enum logic {IDLE, OWN} state_t;
   function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] p);
      return p + SEL_W'(1);
   endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: first active request found scanning ptr, ptr+1, ... modulo 4
module rr_pick4
   import mux4_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic [SEL_W-1:0]   gnt_idx,
   output logic               any
);
   // walk offsets from farthest to nearest so the request closest to ptr is the one left standing
   always_comb begin
      gnt_idx = ptr;
      any = |req;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (req[ptr + SEL_W'(i)]) gnt_idx = ptr + SEL_W'(i);
   end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin, burst-limited 4:1 data mux feeding a registered valid/ready output stage
module mux4_rr_arbiter
   import mux4_arb_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int MAX_BURST = 2
)(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [WIDTH-1:0]   i_data_0,
   input  logic [WIDTH-1:0]   i_data_1,
   input  logic [WIDTH-1:0]   i_data_2,
   input  logic [WIDTH-1:0]   i_data_3,
   output logic [NUM_REQ-1:0] o_ack,
   output logic [WIDTH-1:0]   o_data,
   output logic               o_valid,
   output logic [SEL_W-1:0]   o_sel,
   input  logic               i_ready
);
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);
   state_t state;
   logic [SEL_W-1:0] owner, ptr, pick_idx, win_idx;
   logic [CW-1:0] cnt, cnt_inc;
   logic [WIDTH-1:0] win_data;
   logic load_ok, own_go, pick_any, xfer;
   rr_pick4 u_pick (
      .req(i_req),
      .ptr(ptr),
      .gnt_idx(pick_idx),
      .any(pick_any)
   );
   // winner: the owner keeps the channel while it requests and has burst budget, else round-robin scan
   always_comb begin
      load_ok = !o_valid || i_ready;
      own_go = state == OWN && i_req[owner] && cnt < CMAX;
      win_idx = own_go ? owner : pick_idx;
      xfer = i_rst_n && load_ok && (own_go || pick_any);
      o_ack = xfer ? NUM_REQ'(1) << win_idx : '0;
      win_data = win_idx == 2'd0 ? i_data_0 :
                 win_idx == 2'd1 ? i_data_1 :
                 win_idx == 2'd2 ? i_data_2 : i_data_3;
      cnt_inc = cnt + CW'(1);
   end
   // output register plus ownership FSM; everything freezes while the held word is stalled
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_data <= '0;
         o_sel <= '0;
         ptr <= '0;
         owner <= '0;
         cnt <= '0;
         state <= IDLE;
      end else if (xfer) begin
         o_valid <= 1'b1;
         o_data <= win_data;
         o_sel <= win_idx;
         if (own_go) begin
            cnt <= cnt_inc;
            state <= cnt_inc == CMAX ? IDLE : OWN;
         end else begin
            owner <= win_idx;
            ptr <= rr_next(win_idx);
            cnt <= CW'(1);
            state <= MAX_BURST == 1 ? IDLE : OWN;
         end
      end else if (load_ok) begin
         o_valid <= 1'b0;
         if (state == OWN && !i_req[owner]) state <= IDLE;
      end
   end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed scenarios plus random traffic checked against a behavioural arbiter model
module tb_mux4_rr_arbiter;
   localparam int MB = 2;
   logic clk, rst_n, ready;
   logic [3:0] req, o_ack;
   logic [15:0] d[4];
   logic [15:0] o_data;
   logic o_valid;
   logic [1:0] o_sel;
   int n_chk, n_fail;
   int m_owner, m_used, m_ptr, m_sel;
   bit m_valid;
   logic [15:0] m_data;
   logic [3:0] last_ack, s_ack;
   logic [15:0] s_data;
   logic s_valid;
   logic [1:0] s_sel;

   mux4_rr_arbiter #(.WIDTH(16), .MAX_BURST(MB)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
      .i_data_0(d[0]), .i_data_1(d[1]), .i_data_2(d[2]), .i_data_3(d[3]),
      .o_ack(o_ack), .o_data(o_data), .o_valid(o_valid), .o_sel(o_sel), .i_ready(ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0; m_owner = -1; m_used = 0;
   endtask

   // one cycle: sample and check at negedge, then advance the model across the rising edge
   task automatic step();
      int w;
      bit cont, lok;
      logic [31:0] ea;
      @(negedge clk);
      s_ack = o_ack; s_data = o_data; s_valid = o_valid; s_sel = o_sel;
      w = -1; cont = 0;
      if (m_owner >= 0 && req[m_owner] && m_used < MB) begin w = m_owner; cont = 1; end
      else for (int k = 0; k < 4; k++) if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      lok = !m_valid || ready;
      ea = (rst_n && lok && w >= 0) ? 32'(1 << w) : 32'd0;
      chk("ack", 32'(o_ack), ea);
      chk("valid", 32'(o_valid), 32'(m_valid));
      chk("data", 32'(o_data), 32'(m_data));
      chk("sel", 32'(o_sel), 32'(m_sel));
      last_ack = ea[3:0];
      @(posedge clk);
      if (!rst_n) model_reset();
      else if (lok && w >= 0) begin
         m_valid = 1; m_data = d[w]; m_sel = w;
         if (cont) begin
            m_used++;
            if (m_used == MB) m_owner = -1;
         end else begin
            m_owner = (MB == 1) ? -1 : w; m_used = 1; m_ptr = (w + 1) % 4;
         end
      end else if (lok) begin
         m_valid = 0;
         if (m_owner >= 0 && !req[m_owner]) m_owner = -1;
      end
      #1;
   endtask

   task automatic do_reset(input int n);
      rst_n = 0;
      repeat (n) begin
         step();
         chk("rst_ack", 32'(s_ack), 32'd0);
      end
      rst_n = 1;
   endtask

   initial begin
      n_chk = 0; n_fail = 0; last_ack = '0;
      rst_n = 0; ready = 1; req = 4'b1111;
      d[0] = 16'h0000; d[1] = 16'h000F; d[2] = 16'h0005; d[3] = 16'h0008;
      @(posedge clk); #1;
      model_reset();
      do_reset(2);
      for (int j = 0; j < 10; j++) begin
         step();
         chk("rot_ack", 32'(s_ack), 32'(1 << ((j / 2) % 4)));
         if (j == 0) chk("first_valid", 32'(s_valid), 32'd0);
         else begin
            chk("rot_data", 32'(s_data), 32'(d[((j - 1) / 2) % 4]));
            chk("rot_sel", 32'(s_sel), 32'(((j - 1) / 2) % 4));
            chk("rot_valid", 32'(s_valid), 32'd1);
         end
      end
      do_reset(1);
      req = 4'b0100;
      for (int j = 0; j < 6; j++) begin
         step();
         chk("lone_ack", 32'(s_ack), 32'h4);
         if (j > 0) chk("lone_data", 32'(s_data), 32'h5);
         if (j > 0) chk("lone_valid", 32'(s_valid), 32'd1);
      end
      req = 4'b1111;
      do_reset(1);
      repeat (3) step();
      ready = 0;
      repeat (3) begin
         step();
         chk("bp_ack", 32'(s_ack), 32'd0);
         chk("bp_data", 32'(s_data), 32'hF);
      end
      ready = 1;
      step();
      chk("bp_resume_ack", 32'(s_ack), 32'h2);
      step();
      chk("bp_resume_data", 32'(s_data), 32'hF);
      chk("bp_next_ack", 32'(s_ack), 32'h4);
      do_reset(1);
      req = 4'b0001;
      step();
      chk("er_ack0", 32'(s_ack), 32'h1);
      req = 4'b1000; d[3] = 16'h000B;
      step();
      chk("er_ack3", 32'(s_ack), 32'h8);
      step();
      chk("er_data", 32'(s_data), 32'hB);
      chk("er_sel", 32'(s_sel), 32'd3);
      do_reset(1);
      req = 4'b1000; d[3] = 16'h0008; ready = 0;
      step();
      step();
      chk("mr_stall_data", 32'(s_data), 32'h8);
      rst_n = 0;
      step();
      rst_n = 1; req = 4'b1111; ready = 1;
      step();
      chk("mr_valid", 32'(s_valid), 32'd0);
      chk("mr_data", 32'(s_data), 32'd0);
      chk("mr_ack", 32'(s_ack), 32'h1);
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 4; k++)
            if (last_ack[k] || !req[k]) begin
               req[k] = $urandom_range(0, 3) != 0;
               d[k] = 16'($urandom);
            end
         ready = $urandom_range(0, 3) != 0;
         rst_n = $urandom_range(0, 149) != 0;
         step();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and sequencer for a shared 4:1 16-bit data mux with a registered output. It replaces a static `i_ctrl` select with four requesters, each using a valid/ack handshake. Winning data is loaded into an output register that the downstream side drains with valid/ready. A per-owner burst limit keeps any one requester from monopolising the channel.

Parameters:
- WIDTH, 16, data width of each requester and of `o_data`.
- MAX_BURST, 2, maximum consecutive transfers one owner may make before priority rotates; legal range 1..15.

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_req`  in  4  bit k: requester k has valid data on `i_data_k`. It is held until acked.
- `i_data_0`..`i_data_3`  in  WIDTH each  requester payloads.
- `o_ack`  out  4  one-hot, combinational. Bit k high means requester k transfers on this edge.
- `o_data`  out  WIDTH  registered payload.
- `o_valid`  out  1  `o_data` holds an unconsumed word.
- `o_sel`  out  2  index of the requester whose word is in `o_data`.
- `i_ready`  in  1  downstream accepts `o_data` on this edge when `o_valid` is high.

Behaviour:
- Reset (`i_rst_n`=0 at an edge):
  - `o_valid`=0, `o_data`=0, `o_sel`=0.
  - `ptr`=0, state=IDLE, `cnt`=0.
  - `o_ack` is forced to 0000 while `i_rst_n`=0.
  - Reset mid-transfer drops the held word; no ack is issued.
- Load condition: `load_ok` = !`o_valid` || `i_ready`. A transfer happens when `load_ok` and a winner exists. The winner's `o_ack` bit goes high and the word is registered on that edge.
- Latency: requester word appears on `o_data` one cycle after its ack. Back-to-back transfers run at 1 word/cycle with no bubbles.
- Drain: if `o_valid` && `i_ready` and no transfer, `o_valid`→0 and `o_data`/`o_sel` keep their last value.
- Stall: if `o_valid` && !`i_ready`:
  - `o_ack`=0000.
  - `o_data`, `o_sel`, state, `cnt` and `ptr` are all frozen.
- Winner selection:
  - IDLE: the first set `i_req` bit scanning `ptr`, `ptr`+1, ... (mod 4).
  - OWN with `i_req[owner]`=1 and `cnt`<MAX_BURST: the owner only; other requesters are not acked.
  - OWN with `i_req[owner]`=0: round-robin scan from `ptr` (which equals owner+1).
- State machine (IDLE, OWN); `ptr` rotates only when ownership starts:
  - Transfer by a new winner w: `owner`=w, `ptr`=w+1 mod 4, `cnt`=1. Next state is OWN, or IDLE if MAX_BURST==1.
  - Transfer by the current owner: `cnt`+1. If `cnt`+1==MAX_BURST, next state is IDLE (`ptr` already owner+1).
  - OWN, owner not requesting, no transfer this cycle: next state IDLE.
- Wrap-around: `ptr` 3+1 wraps to 0. `cnt` is width ceil(log2(MAX_BURST+1)) and never exceeds MAX_BURST.
- Simultaneous events:
  - Drain and load on the same edge give a new word with `o_valid` staying 1.
  - A requester that drops its request in the ack cycle violates protocol; behaviour is undefined and the bench must not drive it.

Decomposition:
- Package `mux4_arb_pkg`:
  - constants NUM_REQ=4 and SEL_W=2;
  - state enum {IDLE, OWN};
  - function `rr_next(ptr)` for the mod-4 increment.
- One sub-module, `rr_pick4`: combinational. Inputs are `req[3:0]` and `ptr[1:0]`; outputs are `gnt_idx[1:0]` and `any`. Used for both the IDLE scan and the scan after the owner releases.

Test Plan:
- Reset: `i_rst_n`=0 for 2 cycles, `i_req`=1111, `i_ready`=1 -> `o_ack`=0000, `o_valid`=0, `o_data`=0000. On release, the first ack is 0001 (requester 0).
- Rotation: `i_data_0`..`i_data_3` = 0000, 000F, 0005, 0008; `i_req`=1111; `i_ready`=1; MAX_BURST=2 -> `o_data` = 0000, 0000, 000F, 000F, 0005, 0005, 0008, 0008, 0000..., `o_sel` = 0,0,1,1,2,2,3,3, `o_valid` high throughout.
- Lone requester: only `i_req[2]` high -> 0005 every cycle with no bubble across burst boundaries; `o_ack`=0100 each cycle.
- Backpressure: `o_valid`=1 with `o_data`=000F, `i_ready`=0 for 3 cycles -> `o_data` stays 000F, `o_ack`=0000, `cnt` frozen. Resumes with the second 000F when `i_ready`=1.
- Early release: requester 0 owns with `cnt`=1, then drops `i_req[0]`; `i_req[3]` high with `i_data_3`=000B -> next edge acks 1000, `o_data`=000B, `o_sel`=3, no idle cycle.
- Reset mid-operation: stalled with `o_valid`=1, `o_data`=0008, then `i_rst_n`=0 for 1 cycle -> `o_valid`=0, `o_data`=0000. The next grant with `i_req`=1111 goes to requester 0.
